// File: rtl/nurn_pkg.sv
// nurn_pkg: shared types, encodings and saturating arithmetic for the LIF neuron core
package nurn_pkg;
  localparam int DSIZE = 16;
  localparam int AER_BIT_WIDTH = 32;
  typedef logic signed [DSIZE-1:0] data_t;
  typedef enum logic [2:0] {IDLE, LOAD, ACC, LEAK, FIRE, DONE} state_t;
  typedef enum logic [1:0] {SEL_WEIGHT, SEL_THR, SEL_BIAS, SEL_RSTPOT} cfg_sel_t;
  localparam data_t DATA_MAX = data_t'({1'b0, {(DSIZE-1){1'b1}}});
  localparam data_t DATA_MIN = data_t'({1'b1, {(DSIZE-1){1'b0}}});
  function automatic data_t sat_add(input data_t a, input data_t b);
    logic signed [DSIZE:0] s;
    s = {a[DSIZE-1], a} + {b[DSIZE-1], b};
    return (s[DSIZE] != s[DSIZE-1]) ? (s[DSIZE] ? DATA_MIN : DATA_MAX) : data_t'(s[DSIZE-1:0]);
  endfunction
  function automatic logic [AER_BIT_WIDTH-1:0] packAer(input logic [7:0] x, input logic [7:0] y, input logic [15:0] idx);
    return {x, y, idx};
  endfunction
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: first-word fall-through packet FIFO with valid/ready pop and sticky drop flag
module spike_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int AER_BIT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AER_BIT_WIDTH-1:0] pushData,
  input  logic                     ready,
  output logic                     valid,
  output logic [AER_BIT_WIDTH-1:0] head,
  output logic                     full,
  output logic                     ovf
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [AER_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0] count;
  logic pop, accept;
  assign valid = count != '0;
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign pop = valid && ready;
  // a full FIFO still takes a packet when the head leaves in the same cycle
  assign accept = push && (!full || pop);
  assign head = valid ? mem[rdPtr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept) mem[wrPtr] <= pushData;
      if (accept) wrPtr <= (wrPtr == PW'(FIFO_DEPTH-1)) ? '0 : wrPtr + 1'b1;
      if (pop) rdPtr <= (rdPtr == PW'(FIFO_DEPTH-1)) ? '0 : rdPtr + 1'b1;
      count <= (accept && !pop) ? count + 1'b1 : (!accept && pop) ? count - 1'b1 : count;
      if (push && !accept) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/nurn_core_seq.sv
// nurn_core_seq: time-multiplexed leaky integrate-and-fire core emitting AER spikes through a FIFO
module nurn_core_seq
  import nurn_pkg::*;
#(
  parameter int NUM_NURNS = 4,
  parameter int NUM_AXONS = 8,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC_STEPS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] X_ID = 8'd1,
  parameter logic [7:0] Y_ID = 8'd1,
  localparam int NURN_CNT_BIT_WIDTH = $clog2(NUM_NURNS),
  localparam int AXON_CNT_BIT_WIDTH = $clog2(NUM_AXONS)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [NUM_AXONS-1:0]                         inSpike_i,
  input  logic                                         cfg_we_i,
  input  logic [1:0]                                   cfg_sel_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] cfg_addr_i,
  input  logic [DSIZE-1:0]                             cfg_data_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         spk_valid_o,
  input  logic                                         spk_ready_i,
  output logic [AER_BIT_WIDTH-1:0]                     spk_aer_o,
  output logic                                         ovf_o
);
  localparam int NW = NURN_CNT_BIT_WIDTH;
  localparam int AW = AXON_CNT_BIT_WIDTH;
  localparam int REFRAC_BIT_WIDTH = $clog2(REFRAC_STEPS + 1);
  state_t state, stateNext;
  logic [NW-1:0] nIdx, cfgN;
  logic [AW-1:0] aIdx, cfgA;
  logic [NUM_AXONS-1:0] spikes;
  data_t acc;
  data_t pot [NUM_NURNS];
  data_t thr [NUM_NURNS];
  data_t bias [NUM_NURNS];
  data_t rstPot [NUM_NURNS];
  data_t weight [NUM_NURNS][NUM_AXONS];
  logic [REFRAC_BIT_WIDTH-1:0] refr [NUM_NURNS];
  logic isRefr, lastNurn, lastAxon, fires, push, fifoFull;
  assign cfgN = cfg_addr_i[AW +: NW];
  assign cfgA = cfg_addr_i[AW-1:0];
  assign isRefr = refr[nIdx] != '0;
  assign lastNurn = nIdx == NW'(NUM_NURNS-1);
  assign lastAxon = aIdx == AW'(NUM_AXONS-1);
  assign fires = acc >= thr[nIdx];
  assign push = (state == FIRE) && fires;
  assign busy_o = (state != IDLE) && (state != DONE);
  assign done_o = state == DONE;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = start_i ? LOAD : IDLE;
      LOAD: stateNext = isRefr ? (lastNurn ? DONE : LOAD) : ACC;
      ACC: stateNext = lastAxon ? LEAK : ACC;
      LEAK: stateNext = FIRE;
      FIRE: stateNext = lastNurn ? DONE : LOAD;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= stateNext;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nIdx <= '0;
      aIdx <= '0;
      spikes <= '0;
      acc <= '0;
      for (int n = 0; n < NUM_NURNS; n++) begin
        pot[n] <= '0;
        refr[n] <= '0;
        thr[n] <= DATA_MAX;
        bias[n] <= '0;
        rstPot[n] <= '0;
        for (int a = 0; a < NUM_AXONS; a++) weight[n][a] <= '0;
      end
    end else begin
      if (cfg_we_i && !busy_o)
        case (cfg_sel_t'(cfg_sel_i))
          SEL_WEIGHT: weight[cfgN][cfgA] <= cfg_data_i;
          SEL_THR: thr[cfgN] <= cfg_data_i;
          SEL_BIAS: bias[cfgN] <= cfg_data_i;
          SEL_RSTPOT: rstPot[cfgN] <= cfg_data_i;
        endcase
      case (state)
        IDLE: if (start_i) begin
          spikes <= inSpike_i;
          nIdx <= '0;
        end
        // a refractory neuron is held at its reset potential and skipped in one cycle
        LOAD: if (isRefr) begin
          refr[nIdx] <= refr[nIdx] - 1'b1;
          pot[nIdx] <= rstPot[nIdx];
          nIdx <= nIdx + 1'b1;
        end else begin
          acc <= sat_add(pot[nIdx], bias[nIdx]);
          aIdx <= '0;
        end
        ACC: begin
          if (spikes[aIdx]) acc <= sat_add(acc, weight[nIdx][aIdx]);
          aIdx <= aIdx + 1'b1;
        end
        LEAK: acc <= acc - (acc >>> LEAK_SHIFT);
        FIRE: begin
          pot[nIdx] <= fires ? rstPot[nIdx] : acc;
          if (fires) refr[nIdx] <= REFRAC_BIT_WIDTH'(REFRAC_STEPS);
          nIdx <= nIdx + 1'b1;
        end
        default: ;
      endcase
    end
  end
  spike_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .AER_BIT_WIDTH(AER_BIT_WIDTH)) uFifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pushData(packAer(X_ID, Y_ID, 16'(nIdx))),
    .ready(spk_ready_i),
    .valid(spk_valid_o),
    .head(spk_aer_o),
    .full(fifoFull),
    .ovf(ovf_o)
  );
endmodule

// File: tb/tb_nurn_core_seq.sv
// tb_nurn_core_seq: directed table-driven bench for the LIF neuron core
module tb_nurn_core_seq;
  logic clk = 0, rst = 0, start = 0, cfgWe = 0, spkReady = 0;
  logic [7:0] inSpike = '0;
  logic [1:0] cfgSel = '0;
  logic [4:0] cfgAddr = '0;
  logic [15:0] cfgData = '0;
  logic busy, done, spkValid, ovf;
  logic [31:0] spkAer;
  int total = 0, bad = 0;
  logic [31:0] got [$];
  typedef struct {
    logic [7:0] spk;
    int popAt;
    int expLat;
    logic expValid;
    logic expOvf;
    logic [31:0] expAer;
  } vec_t;
  vec_t refrTab [4];
  vec_t fullTab [4];

  nurn_core_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .inSpike_i(inSpike),
    .cfg_we_i(cfgWe), .cfg_sel_i(cfgSel), .cfg_addr_i(cfgAddr), .cfg_data_i(cfgData),
    .busy_o(busy), .done_o(done), .spk_valid_o(spkValid), .spk_ready_i(spkReady),
    .spk_aer_o(spkAer), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1;
    @(negedge clk);
    @(negedge clk) rst = 0;
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input int n, input int a, input logic [15:0] d);
    @(negedge clk);
    cfgWe = 1;
    cfgSel = sel;
    cfgAddr = {2'(n), 3'(a)};
    cfgData = d;
    @(negedge clk) cfgWe = 0;
  endtask

  task automatic runStep(input logic [7:0] spk, input int popAt, input int expLat, input string tag);
    int lat;
    logic busyAtDone;
    lat = -1;
    busyAtDone = 1'b1;
    @(negedge clk);
    start = 1;
    inSpike = spk;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      @(negedge clk);
      start = 0;
      spkReady = (c == popAt);
      if (c == 1) chk({tag, " busy"}, busy, 1);
      if (done) begin
        lat = c;
        busyAtDone = busy;
      end
    end
    spkReady = 0;
    chk({tag, " latency"}, lat, expLat);
    if (lat > 0) chk({tag, " busy at done"}, busyAtDone, 0);
  endtask

  task automatic drain();
    got = {};
    repeat (8) begin
      @(negedge clk);
      spkReady = 1;
      if (spkValid) got.push_back(spkAer);
    end
    @(negedge clk) spkReady = 0;
  endtask

  task automatic applyVec(input vec_t v, input bit doDrain, input string tag);
    runStep(v.spk, v.popAt, v.expLat, tag);
    chk({tag, " valid"}, spkValid, v.expValid);
    chk({tag, " ovf"}, ovf, v.expOvf);
    chk({tag, " aer"}, spkAer, v.expAer);
    if (doDrain) begin
      drain();
      chk({tag, " drained"}, got.size(), v.expValid);
    end
  endtask

  initial begin
    logic doneSeen;
    refrTab[0] = '{8'h03, 0, 45, 1'b1, 1'b0, 32'h01010000};
    refrTab[1] = '{8'h03, 0, 35, 1'b0, 1'b0, 32'h0};
    refrTab[2] = '{8'h03, 0, 35, 1'b0, 1'b0, 32'h0};
    refrTab[3] = '{8'h03, 0, 45, 1'b1, 1'b0, 32'h01010000};
    fullTab[0] = '{8'h00, 0, 45, 1'b1, 1'b0, 32'h01010000};
    fullTab[1] = '{8'h00, 0, 5, 1'b1, 1'b0, 32'h01010000};
    fullTab[2] = '{8'h00, 0, 5, 1'b1, 1'b0, 32'h01010000};
    fullTab[3] = '{8'h00, 11, 45, 1'b1, 1'b1, 32'h01010001};

    doReset();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset valid", spkValid, 0);
    chk("reset ovf", ovf, 0);
    chk("reset aer", spkAer, 0);

    applyVec('{8'hFF, 0, 45, 1'b0, 1'b0, 32'h0}, 1, "noconfig");

    cfgWrite(2'd0, 0, 0, 16'h0090);
    cfgWrite(2'd0, 0, 1, 16'h0090);
    cfgWrite(2'd1, 0, 0, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      applyVec(refrTab[i], 1, $sformatf("refr%0d", i));
      if (refrTab[i].expValid && got.size() > 0) chk($sformatf("refr%0d pkt", i), got[0], refrTab[i].expAer);
    end

    // neuron1 only fires if eight 0x7F00 adds clamp at 0x7FFF (leak -> 0x7800)
    for (int a = 0; a < 8; a++) cfgWrite(2'd0, 1, a, 16'h7F00);
    cfgWrite(2'd1, 1, 0, 16'h7800);
    applyVec('{8'hFF, 0, 35, 1'b1, 1'b0, 32'h01010001}, 1, "saturate");

    doReset();
    for (int n = 0; n < 4; n++) cfgWrite(2'd1, n, 0, 16'h8000);
    for (int i = 0; i < 4; i++) applyVec(fullTab[i], 0, $sformatf("full%0d", i));
    drain();
    chk("drain count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("drain%0d", i), got[i], 32'h01010000 | 32'((i + 1) % 4));
    chk("ovf sticky", ovf, 1);
    chk("drain empty", spkValid, 0);

    doReset();
    cfgWrite(2'd1, 0, 0, 16'h8000);
    doneSeen = 0;
    @(negedge clk);
    start = 1;
    inSpike = '0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = (c == 5);
      cfgWe = (c == 5);
      cfgSel = 2'd1;
      cfgAddr = '0;
      cfgData = 16'h7FFF;
      if (done) doneSeen = 1;
      if (c == 11) chk("valid before push", spkValid, 0);
      if (c == 12) chk("valid after push", spkValid, 1);
      if (c == 12) chk("aer after push", spkAer, 32'h01010000);
      if (c == 20) rst = 1;
      if (c == 21) begin
        chk("midrst busy", busy, 0);
        chk("midrst valid", spkValid, 0);
        chk("midrst ovf", ovf, 0);
        rst = 0;
      end
    end
    repeat (60) begin
      @(negedge clk);
      if (done) doneSeen = 1;
    end
    chk("midrst no done", doneSeen, 0);
    applyVec('{8'hFF, 0, 45, 1'b0, 1'b0, 32'h0}, 0, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
